lock_entry_controller: RTL and testbench

- Sequences serial code entry for the digital lock datapath.
- Collects CODE_LEN code bits under a valid strobe and compares them against a stored secret.
- Grants a timed openlock window on a correct code.
- Counts consecutive failed attempts and enforces a timed alarm lockout after MAX_FAIL failures.
- Sits between the keypad/serial front end and the lock actuator/alarm drivers.

---
 rtl/lock_entry_controller.sv | 164 ++++++++++++++++
 tb/tb_lock_entry_controller.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_entry_controller.sv
// Serial code-entry sequencer for the digital lock: collects CODE_LEN bits, grants a timed
// open window on a match, and enforces a timed alarm lockout after MAX_FAIL consecutive misses.
module lock_entry_controller #(
   parameter int CODE_LEN       = 4,
   parameter int MAX_FAIL       = 3,
   parameter int OPEN_CYCLES    = 8,
   parameter int LOCKOUT_CYCLES = 16
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              code_valid_i,
   input  logic                              code_i,
   input  logic                              cancel_i,
   input  logic [CODE_LEN-1:0]               secret_i,
   output logic                              openlock_o,
   output logic                              alarm_o,
   output logic                              fail_o,
   output logic                              busy_o,
   output logic [$clog2(MAX_FAIL+1)-1:0]     fail_count_o
);

   // state   | meaning
   // S_IDLE  | waiting for the first code bit; cancel ignored
   // S_ENTRY | collecting remaining bits, mismatch accumulated, no early abort
   // S_OPEN  | openlock held for OPEN_CYCLES or until cancel
   // S_LOCKOUT | alarm held for LOCKOUT_CYCLES, all inputs ignored

   localparam int FCW     = $clog2(MAX_FAIL+1);
   localparam int IW      = $clog2(CODE_LEN);
   localparam int MAX_CYC = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
   localparam int CW      = $clog2(MAX_CYC+1);

   localparam logic [IW-1:0]  IDX_LAST  = IW'(CODE_LEN-1);
   localparam logic [FCW-1:0] FC_LAST   = FCW'(MAX_FAIL-1);
   localparam logic [FCW-1:0] FC_MAX    = FCW'(MAX_FAIL);
   localparam logic [CW-1:0]  OPEN_LOAD = CW'(OPEN_CYCLES-1);
   localparam logic [CW-1:0]  LOCK_LOAD = CW'(LOCKOUT_CYCLES-1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ENTRY   = 2'd1,
      S_OPEN    = 2'd2,
      S_LOCKOUT = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 mism_q, mism_d;
   logic [CODE_LEN-1:0]  secret_q, secret_d;
   logic [FCW-1:0]       fail_count_q, fail_count_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 fail_q, fail_d;
   logic                 openlock_q, alarm_q, busy_q;
   logic                 cur_mism;

   // secret_q is a shifting copy: its MSB is always the bit expected next
   assign cur_mism = code_i ^ secret_q[CODE_LEN-1];

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      mism_d       = mism_q;
      secret_d     = secret_q;
      fail_count_d = fail_count_q;
      cnt_d        = cnt_q;
      fail_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (code_valid_i) begin
               secret_d = {secret_i[CODE_LEN-2:0], 1'b0};
               mism_d   = code_i ^ secret_i[CODE_LEN-1];
               idx_d    = IW'(1);
               state_d  = S_ENTRY;
            end
         end

         S_ENTRY: begin
            if (cancel_i) begin
               idx_d   = '0;
               mism_d  = 1'b0;
               state_d = S_IDLE;
            end else if (code_valid_i) begin
               secret_d = {secret_q[CODE_LEN-2:0], 1'b0};
               if (idx_q == IDX_LAST) begin
                  idx_d  = '0;
                  mism_d = 1'b0;
                  if (!(mism_q | cur_mism)) begin
                     fail_count_d = '0;
                     cnt_d        = OPEN_LOAD;
                     state_d      = S_OPEN;
                  end else if (fail_count_q == FC_LAST) begin
                     fail_count_d = FC_MAX;
                     cnt_d        = LOCK_LOAD;
                     state_d      = S_LOCKOUT;
                  end else begin
                     fail_count_d = fail_count_q + 1'b1;
                     fail_d       = 1'b1;
                     state_d      = S_IDLE;
                  end
               end else begin
                  idx_d  = idx_q + 1'b1;
                  mism_d = mism_q | cur_mism;
               end
            end
         end

         S_OPEN: begin
            if (cancel_i || cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_LOCKOUT: begin
            if (cnt_q == '0) begin
               fail_count_d = '0;
               state_d      = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output flops are driven from the next state so they line up with the state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         mism_q       <= 1'b0;
         secret_q     <= '0;
         fail_count_q <= '0;
         cnt_q        <= '0;
         fail_q       <= 1'b0;
         openlock_q   <= 1'b0;
         alarm_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         mism_q       <= mism_d;
         secret_q     <= secret_d;
         fail_count_q <= fail_count_d;
         cnt_q        <= cnt_d;
         fail_q       <= fail_d;
         openlock_q   <= (state_d == S_OPEN);
         alarm_q      <= (state_d == S_LOCKOUT);
         busy_q       <= (state_d != S_IDLE);
      end
   end

   assign openlock_o   = openlock_q;
   assign alarm_o      = alarm_q;
   assign fail_o       = fail_q;
   assign busy_o       = busy_q;
   assign fail_count_o = fail_count_q;

endmodule

// File: tb/tb_lock_entry_controller.sv
// Directed bench for lock_entry_controller with secret 4'b1010 and default parameters.
module tb_lock_entry_controller;

   logic       clk;
   logic       rst_n;
   logic       code_valid;
   logic       code;
   logic       cancel;
   logic [3:0] secret;
   logic       openlock;
   logic       alarm;
   logic       fail;
   logic       busy;
   logic [1:0] fail_count;

   int n_chk  = 0;
   int n_pass = 0;

   lock_entry_controller #(
      .CODE_LEN(4), .MAX_FAIL(3), .OPEN_CYCLES(8), .LOCKOUT_CYCLES(16)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .code_valid_i (code_valid),
      .code_i       (code),
      .cancel_i     (cancel),
      .secret_i     (secret),
      .openlock_o   (openlock),
      .alarm_o      (alarm),
      .fail_o       (fail),
      .busy_o       (busy),
      .fail_count_o (fail_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got running required finished");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_code(input logic [3:0] c);
      for (int i = 3; i >= 0; i--) begin
         code_valid = 1'b1;
         code       = c[i];
         step();
      end
      code_valid = 1'b0;
      code       = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (busy === 1'b1 && n < 100) begin
         step();
         n++;
      end
      n_chk++;
      if (busy !== 1'b0) $display("FAIL drain_idle: busy=%b required 0", busy);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         code_valid = 1'($urandom);
         code       = 1'($urandom);
         cancel     = 1'($urandom);
         secret     = 4'($urandom);
         step();
      end
      n_chk++;
      if ({openlock, alarm, fail, busy, fail_count} !== 6'b0)
         $display("FAIL reset_outputs: got %b required 000000", {openlock, alarm, fail, busy, fail_count});
      else n_pass++;
      code_valid = 1'b0; code = 1'b0; cancel = 1'b0; secret = 4'b1010;
      rst_n = 1'b1;
      step();
      n_chk++;
      if ({openlock, alarm, fail, busy, fail_count} !== 6'b0)
         $display("FAIL reset_release_idle: got %b required 000000", {openlock, alarm, fail, busy, fail_count});
      else n_pass++;
   endtask

   task automatic test_open();
      int n = 0;
      send_code(4'b1010);
      n_chk++;
      if (openlock !== 1'b1 || alarm !== 1'b0 || busy !== 1'b1 || fail_count !== 2'd0)
         $display("FAIL open_start: ol=%b al=%b busy=%b fc=%0d required 1 0 1 0", openlock, alarm, busy, fail_count);
      else n_pass++;
      while (openlock === 1'b1 && n < 40) begin
         step();
         n++;
      end
      n_chk++;
      if (n !== 8) $display("FAIL open_length: got %0d cycles required 8", n);
      else n_pass++;
      n_chk++;
      if (busy !== 1'b0) $display("FAIL open_busy_fall: busy=%b required 0", busy);
      else n_pass++;
   endtask

   task automatic test_fail();
      send_code(4'b1110);
      n_chk++;
      if (fail !== 1'b1 || fail_count !== 2'd1 || openlock !== 1'b0 || busy !== 1'b0)
         $display("FAIL wrong_code: fail=%b fc=%0d ol=%b busy=%b required 1 1 0 0", fail, fail_count, openlock, busy);
      else n_pass++;
      step();
      n_chk++;
      if (fail !== 1'b0) $display("FAIL fail_pulse_width: fail=%b required 0", fail);
      else n_pass++;
      send_code(4'b1010);
      n_chk++;
      if (openlock !== 1'b1 || fail_count !== 2'd0)
         $display("FAIL open_after_fail: ol=%b fc=%0d required 1 0", openlock, fail_count);
      else n_pass++;
      drain();
   endtask

   task automatic test_lockout();
      int n = 0;
      logic seen_open = 1'b0;
      logic [3:0] lk = 4'b1010;
      send_code(4'b0000);
      n_chk++;
      if (fail !== 1'b1 || fail_count !== 2'd1)
         $display("FAIL lock_first: fail=%b fc=%0d required 1 1", fail, fail_count);
      else n_pass++;
      send_code(4'b1111);
      n_chk++;
      if (fail !== 1'b1 || fail_count !== 2'd2)
         $display("FAIL lock_second: fail=%b fc=%0d required 1 2", fail, fail_count);
      else n_pass++;
      send_code(4'b1011);
      n_chk++;
      if (fail !== 1'b0 || alarm !== 1'b1 || fail_count !== 2'd3 || busy !== 1'b1 || openlock !== 1'b0)
         $display("FAIL lock_third: fail=%b al=%b fc=%0d busy=%b ol=%b required 0 1 3 1 0",
                  fail, alarm, fail_count, busy, openlock);
      else n_pass++;
      while (alarm === 1'b1 && n < 60) begin
         code_valid = (n < 4);
         code       = (n < 4) ? lk[3-n] : 1'b0;
         if (openlock === 1'b1) seen_open = 1'b1;
         step();
         n++;
      end
      code_valid = 1'b0;
      code       = 1'b0;
      n_chk++;
      if (n !== 16) $display("FAIL alarm_length: got %0d cycles required 16", n);
      else n_pass++;
      n_chk++;
      if (seen_open !== 1'b0 || openlock !== 1'b0)
         $display("FAIL lockout_ignores_code: opened=%b required 0", seen_open | openlock);
      else n_pass++;
      n_chk++;
      if (fail_count !== 2'd0 || busy !== 1'b0)
         $display("FAIL lockout_exit: fc=%0d busy=%b required 0 0", fail_count, busy);
      else n_pass++;
      send_code(4'b1010);
      n_chk++;
      if (openlock !== 1'b1) $display("FAIL open_after_lockout: ol=%b required 1", openlock);
      else n_pass++;
      drain();
   endtask

   task automatic test_cancel();
      send_code(4'b0001);
      step();
      code_valid = 1'b1; code = 1'b1; step();
      code = 1'b0; step();
      code = 1'b1; step();
      code = 1'b0; cancel = 1'b1; step();
      code_valid = 1'b0; cancel = 1'b0;
      n_chk++;
      if (openlock !== 1'b0 || fail !== 1'b0 || fail_count !== 2'd1 || busy !== 1'b0)
         $display("FAIL cancel_entry: ol=%b fail=%b fc=%0d busy=%b required 0 0 1 0",
                  openlock, fail, fail_count, busy);
      else n_pass++;
      step();
      n_chk++;
      if (openlock !== 1'b0 || busy !== 1'b0)
         $display("FAIL cancel_stays_idle: ol=%b busy=%b required 0 0", openlock, busy);
      else n_pass++;
      send_code(4'b1010);
      n_chk++;
      if (openlock !== 1'b1 || fail_count !== 2'd0)
         $display("FAIL open_after_cancel: ol=%b fc=%0d required 1 0", openlock, fail_count);
      else n_pass++;
      drain();
   endtask

   task automatic test_open_cancel_and_gaps();
      logic [3:0] c = 4'b1010;
      int gaps [4] = '{3, 5, 0, 2};
      logic bad_gap = 1'b0;
      send_code(4'b1010);
      step();
      step();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      n_chk++;
      if (openlock !== 1'b0 || busy !== 1'b0)
         $display("FAIL open_cancel: ol=%b busy=%b required 0 0", openlock, busy);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         code_valid = 1'b1;
         code       = c[3-i];
         step();
         code_valid = 1'b0;
         if (i < 3) begin
            for (int g = 0; g < gaps[i]; g++) begin
               if (busy !== 1'b1 || openlock !== 1'b0) bad_gap = 1'b1;
               step();
            end
         end
      end
      n_chk++;
      if (bad_gap !== 1'b0) $display("FAIL gap_hold: state lost in gap got 1 required 0");
      else n_pass++;
      n_chk++;
      if (openlock !== 1'b1) $display("FAIL gapped_open: ol=%b required 1", openlock);
      else n_pass++;
      drain();
   endtask

   task automatic test_async_reset();
      code_valid = 1'b1; code = 1'b1; step();
      code = 1'b0; step();
      code_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (busy !== 1'b0) $display("FAIL async_entry: busy=%b required 0", busy);
      else n_pass++;
      #2 rst_n = 1'b1;
      step();
      send_code(4'b1010);
      n_chk++;
      if (openlock !== 1'b1) $display("FAIL open_after_entry_reset: ol=%b required 1", openlock);
      else n_pass++;
      step();
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (openlock !== 1'b0 || busy !== 1'b0)
         $display("FAIL async_open: ol=%b busy=%b required 0 0", openlock, busy);
      else n_pass++;
      #2 rst_n = 1'b1;
      step();
      send_code(4'b0000);
      send_code(4'b1111);
      send_code(4'b0110);
      step();
      step();
      n_chk++;
      if (alarm !== 1'b1 || fail_count !== 2'd3)
         $display("FAIL lockout_before_reset: al=%b fc=%0d required 1 3", alarm, fail_count);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (alarm !== 1'b0 || fail_count !== 2'd0 || busy !== 1'b0)
         $display("FAIL async_lockout: al=%b fc=%0d busy=%b required 0 0 0", alarm, fail_count, busy);
      else n_pass++;
      #2 rst_n = 1'b1;
      step();
   endtask

   task automatic test_secret_change();
      code_valid = 1'b1; code = 1'b1; step();
      secret = 4'b0101;
      code = 1'b0; step();
      code = 1'b1; step();
      code = 1'b0; step();
      code_valid = 1'b0;
      n_chk++;
      if (openlock !== 1'b1 || fail !== 1'b0)
         $display("FAIL secret_change: ol=%b fail=%b required 1 0", openlock, fail);
      else n_pass++;
      drain();
      send_code(4'b0101);
      n_chk++;
      if (openlock !== 1'b1) $display("FAIL new_secret_open: ol=%b required 1", openlock);
      else n_pass++;
      drain();
      secret = 4'b1010;
   endtask

   initial begin
      rst_n = 1'b0; code_valid = 1'b0; code = 1'b0; cancel = 1'b0; secret = 4'b1010;
      test_reset();
      test_open();
      test_fail();
      test_lockout();
      test_cancel();
      test_open_cancel_and_gaps();
      test_async_reset();
      test_secret_change();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
